ifu_prefetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end for the 5-stage RV64 core; replaces the single-entry IF stage.
//  - Issues one-word fetch requests over a valid/ready memory port.
//  - Buffers returned instructions with their PCs in a DEPTH-entry FIFO.
//  - Presents FIFO entries to ID through a valid/ready handshake.
//  - Handles redirects (branch taken in ID, mret in WB): flushes the FIFO and discards an in-flight stale response.

---
 rtl/ifu_prefetch_queue.sv | 148 ++++++++++++++
 tb/tb_ifu_prefetch_queue.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch_queue.sv
// Instruction-fetch front end: a single-outstanding fetch engine feeding a
// DEPTH-entry PC/instruction FIFO toward decode, flushed on redirect.
module ifu_prefetch_queue #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h8000_0000,
  parameter int              DEPTH    = 4,
  parameter int              MEM_W    = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redir_valid,
  input  logic [PC_W-1:0]          redir_pc,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [PC_W-1:0]          req_addr,
  input  logic                     resp_valid,
  input  logic [MEM_W-1:0]         resp_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [31:0]              out_inst,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF_W = $clog2(MEM_W / 8);
  localparam logic [PC_W-1:0]  ALIGN_MASK = ~PC_W'((1 << OFF_W) - 1);
  localparam logic [PC_W-1:0]  WORD_MASK  = ~PC_W'(3);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [PC_W-1:0]   fpc;
  logic [PC_W-1:0]   fpc_next;
  logic [PC_W-1:0]   req_pc;
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [31:0]       inst_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [31:0]       resp_inst;
  logic              req_fire;
  logic              push;
  logic              pop;

  assign push      = (state == S_WAIT) && resp_valid && !redir_valid;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign req_addr  = fpc & ALIGN_MASK;
  assign out_pc    = pc_mem[rd_ptr];
  assign out_inst  = inst_mem[rd_ptr];
  assign occupancy = count;

  // The upper word of a doubleword response belongs to PCs with bit 2 set.
  always_comb begin
    resp_inst = resp_data[31:0];
    if (MEM_W == 64 && req_pc[2]) begin
      resp_inst = resp_data[MEM_W-1 -: 32];
    end
  end

  always_comb begin
    state_next = state;
    req_valid  = 1'b0;
    req_fire   = 1'b0;
    case (state)
      S_REQ: begin
        req_valid = (count < FULL_CNT);
        req_fire  = req_valid && req_ready;
        if (req_fire) begin
          state_next = redir_valid ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (resp_valid) begin
          state_next = S_REQ;
        end else if (redir_valid) begin
          state_next = S_DROP;
        end
      end
      S_DROP: begin
        if (resp_valid) begin
          state_next = S_REQ;
        end
      end
      default: state_next = S_REQ;
    endcase
  end

  always_comb begin
    fpc_next = fpc;
    if (redir_valid) begin
      fpc_next = redir_pc & WORD_MASK;
    end else if (push) begin
      fpc_next = fpc + PC_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_REQ;
      fpc    <= RESET_PC & WORD_MASK;
      req_pc <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      fpc   <= fpc_next;
      if (req_fire) begin
        req_pc <= fpc;
      end
      // A redirect empties the queue even if decode pops in the same cycle.
      if (redir_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (push && !pop) begin
          count <= count + CNT_W'(1);
        end else if (pop && !push) begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= req_pc;
      inst_mem[wr_ptr] <= resp_inst;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Bench for ifu_prefetch_queue: directed fetch/redirect/reset scenarios with a
// scoreboard of expected {pc, inst} entries checked by an independent monitor.
module tb_ifu_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic        track = 1'b0;

  // Memory model: one outstanding request answered after lat cycles.
  int          lat = 1;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] pend_pc = '0;
  logic        pend_stale = 1'b0;
  logic [31:0] fpc_m = RESET_PC;

  ifu_prefetch_queue #(
    .PC_W(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH), .MEM_W(64)
  ) dut (
    .clk(clk), .rst(rst),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .occupancy(occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [63:0] mem_dword(input logic [31:0] a);
    logic [31:0] base;
    base = a & 32'hFFFF_FFF8;
    return {inst_of(base | 32'h4), inst_of(base)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle: check post-edge outputs against the model, drive inputs,
  // play the memory, then advance past the next rising edge.
  task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] rpc,
                               input logic rr, input logic ordy);
    logic [31:0] cur_fpc;
    logic        resp_now;
    logic        keep;
    logic        exp_req;
    if (track) begin
      exp_req = !pend && (exp_q.size() < DEPTH);
      checkOutput("occupancy", 64'(occupancy), 64'(exp_q.size()));
      checkOutput("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      checkOutput("req_valid", 64'(req_valid), 64'(exp_req));
      if (exp_req) checkOutput("req_addr", 64'(req_addr), 64'(fpc_m & 32'hFFFF_FFF8));
    end
    cur_fpc     = fpc_m;
    rst         = r;
    redir_valid = rv;
    redir_pc    = rpc;
    req_ready   = rr;
    out_ready   = ordy;
    resp_valid  = 1'b0;
    resp_now    = 1'b0;
    if (r) pend = 1'b0;
    if (pend) begin
      if (pend_cnt <= 1) begin
        resp_now   = 1'b1;
        resp_valid = 1'b1;
        resp_data  = mem_dword(pend_addr);
        pend       = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    keep = resp_now && !pend_stale && !rv && !r;
    if (keep) exp_q.push_back({pend_pc, inst_of(pend_pc)});
    if (r) fpc_m = RESET_PC;
    else if (rv) fpc_m = rpc & 32'hFFFF_FFFC;
    else if (keep) fpc_m = fpc_m + 32'd4;
    if (rv && pend) pend_stale = 1'b1;
    #1;
    if (!r && req_valid === 1'b1 && req_ready) begin
      pend       = 1'b1;
      pend_cnt   = lat;
      pend_addr  = req_addr;
      pend_pc    = cur_fpc;
      pend_stale = rv;
    end
    @(posedge clk);
    #1;
    if (r || rv) exp_q.delete();
  endtask

  task automatic runCycles(input int n, input logic rr, input logic ordy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, rr, ordy);
  endtask

  // Monitor: every accepted head entry must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pop: got pc %h, expected no entry at %0t", out_pc, $time);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("out_pc", 64'(out_pc), 64'(mon_e[63:32]));
          checkOutput("out_inst", 64'(out_inst), 64'(mon_e[31:0]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; redir_valid = 1'b0; redir_pc = '0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_data = '0; out_ready = 1'b0;

    // T1: reset values after the first reset edge
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("t1_req_valid", 64'(req_valid), 64'd1);
    checkOutput("t1_req_addr", 64'(req_addr), 64'h8000_0000);
    checkOutput("t1_out_valid", 64'(out_valid), 64'd0);
    checkOutput("t1_occupancy", 64'(occupancy), 64'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    track = 1'b1;

    // T2: streaming through a 1-cycle memory
    lat = 1;
    runCycles(12, 1'b1, 1'b1);

    // T3: fill to DEPTH, then a single pop reopens fetch
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    runCycles(10, 1'b1, 1'b0);
    checkOutput("t3_occupancy", 64'(occupancy), 64'd4);
    checkOutput("t3_req_valid", 64'(req_valid), 64'd0);
    checkOutput("t3_head_pc", 64'(out_pc), 64'h8000_0000);
    checkOutput("t3_head_inst", 64'(out_inst), 64'(inst_of(32'h8000_0000)));
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("t3_req_valid_after_pop", 64'(req_valid), 64'd1);
    checkOutput("t3_req_addr_after_pop", 64'(req_addr), 64'h8000_0010);

    // T4: redirect while a request is outstanding
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    lat = 3;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h8000_0100, 1'b1, 1'b0);
    runCycles(2, 1'b1, 1'b0);
    checkOutput("t4_req_valid", 64'(req_valid), 64'd1);
    checkOutput("t4_req_addr", 64'(req_addr), 64'h8000_0100);
    checkOutput("t4_occupancy", 64'(occupancy), 64'd0);
    lat = 1;
    runCycles(2, 1'b1, 1'b0);
    checkOutput("t4_out_valid", 64'(out_valid), 64'd1);
    checkOutput("t4_out_pc", 64'(out_pc), 64'h8000_0100);

    // T5a: redirect in the same cycle as the request handshake
    applyStimulus(1'b0, 1'b1, 32'h8000_0200, 1'b1, 1'b0);
    checkOutput("t5a_out_valid", 64'(out_valid), 64'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("t5a_req_valid", 64'(req_valid), 64'd1);
    checkOutput("t5a_req_addr", 64'(req_addr), 64'h8000_0200);
    checkOutput("t5a_occupancy", 64'(occupancy), 64'd0);

    // T5b: redirect in the same cycle as the response; low pc bits ignored
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h8000_0306, 1'b1, 1'b0);
    checkOutput("t5b_req_valid", 64'(req_valid), 64'd1);
    checkOutput("t5b_req_addr", 64'(req_addr), 64'h8000_0300);
    checkOutput("t5b_occupancy", 64'(occupancy), 64'd0);
    runCycles(2, 1'b1, 1'b0);
    checkOutput("t5b_out_pc", 64'(out_pc), 64'h8000_0304);
    checkOutput("t5b_out_inst", 64'(out_inst), 64'(inst_of(32'h8000_0304)));

    // T6: reset with three entries queued and a request outstanding
    runCycles(4, 1'b1, 1'b0);
    checkOutput("t6_occupancy_before", 64'(occupancy), 64'd3);
    lat = 3;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("t6_occupancy", 64'(occupancy), 64'd0);
    checkOutput("t6_req_valid", 64'(req_valid), 64'd1);
    checkOutput("t6_req_addr", 64'(req_addr), 64'h8000_0000);

    // T6b: reset while a stale response is being dropped
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h8000_0500, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("t6b_occupancy", 64'(occupancy), 64'd0);
    checkOutput("t6b_req_valid", 64'(req_valid), 64'd1);
    checkOutput("t6b_req_addr", 64'(req_addr), 64'h8000_0000);
    checkOutput("t6b_out_valid", 64'(out_valid), 64'd0);

    // Recovery stream with a 2-cycle memory, then drain
    lat = 2;
    runCycles(12, 1'b1, 1'b1);
    runCycles(8, 1'b0, 1'b1);
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    checkOutput("final_occupancy", 64'(occupancy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
